param_memory: RTL and testbench
===============================

PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 16, meaning the width of the Din/Dout data path in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 16, meaning the width of the address port.
REQ-003 The block SHALL expose parameter DEPTH, default 256, meaning the number of stored words, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL expose parameter RD_LAT, default 1, meaning the read latency in cycles; legal values are 1 and 2.
REQ-005 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  is the reset; it SHALL be synchronous and active-low.
REQ-007 read  input  1  is the read request strobe, sampled each cycle.
REQ-008 write  input  1  is the write request strobe, sampled each cycle.
REQ-009 address  input  ADDR_W  is the word address for the request.
REQ-010 Din  input  DATA_W  is the write data.
REQ-011 Dout  output  DATA_W  is the read data, registered.
REQ-012 dout_valid  output  1  SHALL pulse high for one cycle when Dout carries new read data.
REQ-013 busy  output  1  SHALL be high while requests are not accepted.
REQ-014 addr_err  output  1  SHALL pulse high for one cycle after an accepted request with address >= DEPTH.

Function
REQ-015 A request SHALL be accepted in any cycle where busy=0 and (read|write)=1; requests made while busy=1 SHALL be ignored without side effects.
REQ-016 When read and write are both high, the read SHALL be performed and the write SHALL be dropped.
REQ-017 An accepted write with address < DEPTH SHALL store Din[DATA_W-1:0] at address; it SHALL be visible to a read accepted in the next cycle.
REQ-018 An accepted read SHALL drive Dout and assert dout_valid exactly RD_LAT cycles after the accepting edge; back-to-back reads SHALL produce back-to-back valid results (throughput 1 per cycle).
REQ-019 Dout SHALL hold its last value when no read result is delivered.
REQ-020 A read with address >= DEPTH SHALL return 0 on Dout with dout_valid asserted at normal latency; a write with address >= DEPTH SHALL not modify any word.
REQ-021 addr_err SHALL assert one cycle after the accepting edge of an out-of-range request, independent of RD_LAT.
REQ-022 Internal state machine SHALL have states CLEAR and IDLE: CLEAR -> IDLE after the last word is cleared; IDLE is terminal until reset.
REQ-023 busy SHALL be high exactly while in CLEAR.

Reset
REQ-024 While rst_n=0 at a rising edge: Dout=0, dout_valid=0, addr_err=0, the read pipeline SHALL be flushed, and the state SHALL enter CLEAR (macro defined) or IDLE (macro undefined).
REQ-025 Reset asserted mid-sweep or with reads in flight SHALL discard in-flight results (no dout_valid after reset) and restart the sweep from word 0.
REQ-026 Stored data SHALL be undefined after power-up and not altered by reset alone when the macro is undefined.

Configuration
REQ-027 Macro PARAM_MEMORY_CLEAR_EN: when defined, after reset release the block SHALL write 0 to words 0..DEPTH-1, one word per cycle, busy=1 for exactly DEPTH cycles, then enter IDLE.
REQ-028 When PARAM_MEMORY_CLEAR_EN is undefined, the CLEAR state SHALL not exist, busy SHALL be tied 0, and requests SHALL be accepted in the first cycle after reset release.

Verification
REQ-029 Write 0x00A5 to address 3, read address 3 next cycle, RD_LAT=1 -> Dout=0x00A5 with dout_valid high exactly 1 cycle after read edge.
REQ-030 RD_LAT=2, reads of addresses 0,1,2 on consecutive cycles after writing 0x11,0x22,0x33 -> Dout 0x11,0x22,0x33 on three consecutive cycles starting 2 cycles after first read.
REQ-031 read=1 and write=1 to address 5 (holding 0x07) with Din=0x99 -> Dout=0x07; subsequent read of 5 -> 0x07.
REQ-032 DEPTH=256, read address 300 -> Dout=0, dout_valid=1, addr_err=1 one cycle after; write to 300 leaves all words unchanged.
REQ-033 PARAM_MEMORY_CLEAR_EN defined, DEPTH=16: release reset -> busy high 16 cycles, reads during busy ignored (no dout_valid); then reads of every address return 0.
REQ-034 Assert rst_n=0 at sweep word 8 with a read in flight -> no dout_valid, sweep restarts at 0 and busy lasts full DEPTH cycles after release.

Source files
------------

// File: rtl/param_memory_if.sv
// Request/response bus of param_memory.
// A request is taken at a rising edge when busy=0 and read|write=1; no ready/valid back-pressure
// exists beyond busy, and results come back unconditionally on Dout/dout_valid.
interface param_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] Din;
    logic [DATA_W-1:0] Dout;
    logic              dout_valid;
    logic              busy;
    logic              addr_err;

    modport master (
        output read, write, address, Din,
        input  Dout, dout_valid, busy, addr_err
    );

    modport slave (
        input  read, write, address, Din,
        output Dout, dout_valid, busy, addr_err
    );
endinterface

// File: rtl/param_memory.sv
// Single-port word memory with a 1- or 2-cycle registered read path and out-of-range flagging.
// Define PARAM_MEMORY_CLEAR_EN to zero every word after reset (busy while sweeping).
module param_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    param_memory_if.slave bus,
    output logic          state_dbg
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy_i;
    logic              accept;
    logic              acc_rd;
    logic              acc_wr;
    logic              in_range;
    logic              clr_we;
    logic [IW-1:0]     clr_idx;
    logic              mem_we;
    logic [IW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_range = ({1'b0, bus.address} < DEPTH_A);
    assign accept   = !busy_i && (bus.read || bus.write);
    // Read wins when both strobes are high; the write is simply dropped.
    assign acc_rd   = accept && bus.read;
    assign acc_wr   = accept && bus.write && !bus.read;

`ifdef PARAM_MEMORY_CLEAR_EN
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] clr_idx_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we     = 1'b1;
                clr_idx_nx = clr_idx + IW'(1);
                if (clr_idx == LAST_IDX) begin
                    state_nx   = IDLE;
                    clr_idx_nx = '0;
                end
            end
            default: ;
        endcase
    end

    assign busy_i    = (state == CLEAR);
    assign state_dbg = state;
`else
    assign clr_we    = 1'b0;
    assign clr_idx   = '0;
    assign busy_i    = 1'b0;
    assign state_dbg = 1'b0;
`endif

    assign bus.busy = busy_i;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.address[IW-1:0];
        mem_wdata = bus.Din;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx;
            mem_wdata = '0;
        end else if (acc_wr && in_range) begin
            mem_we = 1'b1;
        end
    end

    // Storage has no reset: contents survive rst_n unless the clear sweep runs.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic              s1_v;
    logic              s1_err;
    logic [DATA_W-1:0] s1_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_err <= 1'b0;
        end else begin
            s1_v   <= acc_rd;
            s1_err <= accept && !in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_rd) begin
            s1_d <= in_range ? mem[bus.address[IW-1:0]] : '0;
        end
    end

    logic              dv_pre;
    logic [DATA_W-1:0] d_pre;

    if (RD_LAT == 2) begin : g_lat2
        logic              s2_v;
        logic [DATA_W-1:0] s2_d;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s2_v <= 1'b0;
            end else begin
                s2_v <= s1_v;
            end
        end

        always_ff @(posedge clk) begin
            if (s1_v) begin
                s2_d <= s1_d;
            end
        end

        assign dv_pre = s2_v;
        assign d_pre  = s2_d;
    end else begin : g_lat1
        assign dv_pre = s1_v;
        assign d_pre  = s1_d;
    end

    // addr_err taps stage 1 directly so its timing does not move with RD_LAT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.Dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.addr_err   <= 1'b0;
        end else begin
            bus.dout_valid <= dv_pre;
            bus.addr_err   <= s1_err;
            if (dv_pre) begin
                bus.Dout <= d_pre;
            end
        end
    end
endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory: two instances (RD_LAT=1/DEPTH=256, RD_LAT=2/DEPTH=16) checked each cycle
// against an event-queue reference model, plus a directed vector table and reset/sweep sequences.
module tb_param_memory;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int D1 = 256;
    localparam int L1 = 1;
    localparam int D2 = 16;
    localparam int L2 = 2;
`ifdef PARAM_MEMORY_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg1;
    logic dbg2;

    always #5 clk = ~clk;

    param_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    param_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    param_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D1), .RD_LAT(L1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(dbg1)
    );
    param_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D2), .RD_LAT(L2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .state_dbg(dbg2)
    );

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } stim_t;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          ev;
        logic [DW-1:0] ed;
        logic          ee;
    } vec_t;

    typedef struct {
        int            dut;
        int            due;
        bit            is_rd;
        logic [DW-1:0] data;
        bit            known;
    } ev_t;

    int            n_checks = 0;
    int            n_fail = 0;
    int            edge_n = 0;
    int            depth [2];
    int            lat [2];
    int            clear_left [2];
    logic [DW-1:0] m_mem [2][256];
    bit            m_known [2][256];
    ev_t           ev_q [$];
    logic          exp_valid [2];
    logic          exp_err [2];
    logic [DW-1:0] exp_dout [2];
    bit            exp_known [2];
    stim_t         idle_s;

    function automatic stim_t mk(input logic rd, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] din);
        stim_t s;
        s.rd = rd;
        s.wr = wr;
        s.addr = addr;
        s.din = din;
        return s;
    endfunction

    task automatic check(input string name, input int d, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @edge %0d: got 0x%0h, expected 0x%0h", name, d + 1, edge_n, act, exp);
        end
    endtask

    // Reference model: requests become timed delivery events; memory is a plain array.
    task automatic model_edge(input int d, input stim_t s, input bit r);
        ev_t keep [$];
        ev_t e;
        bit  inr;
        int  a;
        exp_valid[d] = 1'b0;
        exp_err[d] = 1'b0;
        if (!r) begin
            foreach (ev_q[i]) if (ev_q[i].dut != d) keep.push_back(ev_q[i]);
            ev_q = keep;
            exp_dout[d] = '0;
            exp_known[d] = 1'b1;
            clear_left[d] = CLR ? depth[d] : 0;
            return;
        end
        foreach (ev_q[i]) begin
            if (ev_q[i].dut == d && ev_q[i].due == edge_n) begin
                if (ev_q[i].is_rd) begin
                    exp_valid[d] = 1'b1;
                    exp_dout[d] = ev_q[i].data;
                    exp_known[d] = ev_q[i].known;
                end else begin
                    exp_err[d] = 1'b1;
                end
            end else begin
                keep.push_back(ev_q[i]);
            end
        end
        ev_q = keep;
        if (clear_left[d] > 0) begin
            a = depth[d] - clear_left[d];
            m_mem[d][a] = '0;
            m_known[d][a] = 1'b1;
            clear_left[d]--;
        end else if (s.rd || s.wr) begin
            a = int'(s.addr);
            inr = (a < depth[d]);
            if (!inr) begin
                e.dut = d; e.due = edge_n + 1; e.is_rd = 1'b0; e.data = '0; e.known = 1'b1;
                ev_q.push_back(e);
            end
            if (s.rd) begin
                e.dut = d; e.due = edge_n + lat[d]; e.is_rd = 1'b1;
                e.data = inr ? m_mem[d][a] : '0;
                e.known = inr ? m_known[d][a] : 1'b1;
                ev_q.push_back(e);
            end else if (inr) begin
                m_mem[d][a] = s.din;
                m_known[d][a] = 1'b1;
            end
        end
    endtask

    task automatic check_dut(input int d, input logic [DW-1:0] dout, input logic dv,
                             input logic ae, input logic bz, input logic dbg);
        check("dout_valid", d, DW'(dv), DW'(exp_valid[d]));
        check("addr_err", d, DW'(ae), DW'(exp_err[d]));
        check("busy", d, DW'(bz), DW'(clear_left[d] > 0));
        check("state_dbg", d, DW'(dbg), DW'(clear_left[d] > 0));
        if (exp_known[d]) check("dout", d, dout, exp_dout[d]);
    endtask

    task automatic cycle(input bit r, input stim_t a, input stim_t b);
        rst_n = r;
        bus1.read = a.rd; bus1.write = a.wr; bus1.address = a.addr; bus1.Din = a.din;
        bus2.read = b.rd; bus2.write = b.wr; bus2.address = b.addr; bus2.Din = b.din;
        @(posedge clk);
        edge_n++;
        model_edge(0, a, r);
        model_edge(1, b, r);
        #1;
        check_dut(0, bus1.Dout, bus1.dout_valid, bus1.addr_err, bus1.busy, dbg1);
        check_dut(1, bus2.Dout, bus2.dout_valid, bus2.addr_err, bus2.busy, dbg2);
    endtask

    task automatic wait_idle(input int limit);
        int g = 0;
        while ((bus1.busy || bus2.busy) && g < limit) begin
            cycle(1'b1, idle_s, idle_s);
            g++;
        end
        check("idle_wait", 0, DW'(g < limit), DW'(1'b1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [13];
        stim_t sa;
        stim_t sb;
        int    nv;
        int    g;
        int    bcnt1;
        int    bcnt2;
        logic  rr;

        depth[0] = D1; depth[1] = D2;
        lat[0] = L1; lat[1] = L2;
        for (int d = 0; d < 2; d++) begin
            clear_left[d] = 0;
            exp_dout[d] = '0;
            exp_known[d] = 1'b0;
            for (int i = 0; i < 256; i++) m_known[d][i] = 1'b0;
        end
        idle_s = '0;

        //            rd    wr    addr     din       valid dout      err
        tbl[0]  = '{1'b0, 1'b1, 16'd44,  16'h1234, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'd3,   16'h00A5, 1'b0, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'd3,   16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'd5,   16'h0007, 1'b1, 16'h00A5, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 16'd5,   16'h0099, 1'b0, 16'h00A5, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'd5,   16'h0000, 1'b1, 16'h0007, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'd0,   16'h0000, 1'b1, 16'h0007, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'd300, 16'h0000, 1'b0, 16'h0007, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 16'd300, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 16'd44,  16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 16'd3,   16'h0000, 1'b1, 16'h1234, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'd0,   16'h0000, 1'b1, 16'h00A5, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 16'd0,   16'h0000, 1'b0, 16'h00A5, 1'b0};

        cycle(1'b0, idle_s, idle_s);
        cycle(1'b0, idle_s, idle_s);
        wait_idle(2000);

        for (int i = 0; i < 13; i++) begin
            cycle(1'b1, mk(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din), idle_s);
            check("tbl_valid", 0, DW'(bus1.dout_valid), DW'(tbl[i].ev));
            check("tbl_dout", 0, bus1.Dout, tbl[i].ed);
            check("tbl_err", 0, DW'(bus1.addr_err), DW'(tbl[i].ee));
        end

        // RD_LAT=2 back-to-back reads.
        cycle(1'b1, idle_s, mk(1'b0, 1'b1, 16'd0, 16'h0011));
        cycle(1'b1, idle_s, mk(1'b0, 1'b1, 16'd1, 16'h0022));
        cycle(1'b1, idle_s, mk(1'b0, 1'b1, 16'd2, 16'h0033));
        for (int k = 0; k < 6; k++) begin
            sb = (k < 3) ? mk(1'b1, 1'b0, AW'(k), 16'h0) : idle_s;
            cycle(1'b1, idle_s, sb);
            check("lat2_valid", 1, DW'(bus2.dout_valid), DW'(k >= 2 && k <= 4));
            if (k >= 2 && k <= 4) check("lat2_dout", 1, bus2.Dout, DW'(16'h11 * (k - 1)));
        end

        // Reset with reads in flight on both instances.
        cycle(1'b1, mk(1'b1, 1'b0, 16'd5, 16'h0), mk(1'b1, 1'b0, 16'd1, 16'h0));
        cycle(1'b0, idle_s, idle_s);
        cycle(1'b0, idle_s, idle_s);
        nv = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, idle_s, idle_s);
            nv += int'(bus1.dout_valid) + int'(bus2.dout_valid);
        end
        check("flushed_valid_count", 0, DW'(nv), DW'(0));

        // Reads during the sweep, then reset when word 8 is next.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, mk(1'b1, 1'b0, AW'(k), 16'h0), mk(1'b1, 1'b0, AW'(k), 16'h0));
        end
        cycle(1'b0, idle_s, idle_s);
        bcnt1 = int'(bus1.busy);
        bcnt2 = int'(bus2.busy);
        g = 0;
        while ((bus1.busy || bus2.busy) && g < 2000) begin
            cycle(1'b1, mk(1'b1, 1'b0, AW'(g % 16), 16'h0), mk(1'b1, 1'b0, AW'(g % 16), 16'h0));
            bcnt1 += int'(bus1.busy);
            bcnt2 += int'(bus2.busy);
            g++;
        end
        check("busy_timeout", 0, DW'(g < 2000), DW'(1'b1));
        check("busy_cycles", 0, DW'(bcnt1), DW'(CLR ? D1 : 0));
        check("busy_cycles", 1, DW'(bcnt2), DW'(CLR ? D2 : 0));

        for (int k = 0; k < D2 + 3; k++) begin
            sb = (k < D2) ? mk(1'b1, 1'b0, AW'(k), 16'h0) : idle_s;
            cycle(1'b1, idle_s, sb);
        end

        for (int k = 0; k < 500; k++) begin
            rr = ($urandom_range(0, 199) != 0);
            sa = mk($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 45,
                    ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 299)),
                    DW'($urandom));
            sb = mk($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 45,
                    AW'($urandom_range(0, 19)), DW'($urandom));
            cycle(rr, sa, sb);
        end
        for (int k = 0; k < 4; k++) cycle(1'b1, idle_s, idle_s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
